// File: rtl/gen_fifo_pkg.sv
// Shared constants, pointer type and width helper for the generic FIFO family.
package gen_fifo_pkg;

    localparam int GEN_FIFO_AW = 3;
    localparam int GEN_FIFO_DP = 1 << GEN_FIFO_AW;

    typedef logic [GEN_FIFO_AW:0] gen_ptr_t;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++)
            if ((1 << i) < n) r = i + 1;
        return r;
    endfunction

endpackage

// File: rtl/gen_lead_cnt.sv
// Counts the leading run of ones in a fire vector, starting at bit 0.
module gen_lead_cnt
    import gen_fifo_pkg::*;
#(
    parameter int N  = 2,
    parameter int CW = clog2(N + 1)
) (
    input  logic [N-1:0]  fire,
    output logic [CW-1:0] cnt
);

    logic run;

    always_comb begin
        cnt = '0;
        run = 1'b1;
        for (int i = 0; i < N; i++) begin
            run = run & fire[i];
            if (run) cnt = CW'(i + 1);
        end
    end

endmodule

// File: rtl/gen_mp_fifo.sv
// Multi-port register-based circular FIFO, IN push lanes and OUT pop lanes.
// Define GEN_MP_FIFO_EXPOSE_EN to expose raw storage and per-slot valid bits.
module gen_mp_fifo
    import gen_fifo_pkg::*;
#(
    parameter int DW  = 64,
    parameter int AW  = GEN_FIFO_AW,
    parameter int IN  = 2,
    parameter int OUT = 2
) (
    input  logic                CLK,
    input  logic                RSTn,
    input  logic                flush,
    input  logic [IN-1:0]       push_valid,
    output logic [IN-1:0]       push_ready,
    input  logic [IN*DW-1:0]    data_push,
    output logic [OUT-1:0]      pop_valid,
    input  logic [OUT-1:0]      pop_ready,
    output logic [OUT*DW-1:0]   data_pop,
    output logic [AW:0]         count
`ifdef GEN_MP_FIFO_EXPOSE_EN
    ,
    output logic [(DW<<AW)-1:0] expose_o,
    output logic [(1<<AW)-1:0]  valid
`endif
);

    localparam int DP = 1 << AW;
    localparam int PW = clog2(IN + 1);
    localparam int QW = clog2(OUT + 1);

    logic [DW-1:0]  mem [DP];
    logic [AW:0]    rd_ptr;
    logic [AW:0]    wr_ptr;
    logic [AW:0]    free;
    logic [IN-1:0]  push_fire;
    logic [OUT-1:0] pop_fire;
    logic [PW-1:0]  np;
    logic [QW-1:0]  nq;
    logic [AW-1:0]  waddr [IN];
    logic [AW-1:0]  raddr [OUT];

    assign count = wr_ptr - rd_ptr;
    assign free  = (AW+1)'(DP) - count;

    // Ready/valid derive only from registered pointers: no same-cycle bypass.
    always_comb begin
        for (int i = 0; i < IN; i++) begin
            push_ready[i] = free > (AW+1)'(i);
            waddr[i]      = wr_ptr[AW-1:0] + AW'(i);
        end
    end

    always_comb begin
        data_pop = '0;
        for (int j = 0; j < OUT; j++) begin
            pop_valid[j]          = count > (AW+1)'(j);
            raddr[j]              = rd_ptr[AW-1:0] + AW'(j);
            data_pop[DW*j +: DW]  = mem[raddr[j]];
        end
    end

    assign push_fire = push_valid & push_ready;
    assign pop_fire  = pop_valid & pop_ready;

    gen_lead_cnt #(.N(IN)) u_push_cnt (
        .fire (push_fire),
        .cnt  (np)
    );

    gen_lead_cnt #(.N(OUT)) u_pop_cnt (
        .fire (pop_fire),
        .cnt  (nq)
    );

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            wr_ptr <= wr_ptr + (AW+1)'(np);
            rd_ptr <= rd_ptr + (AW+1)'(nq);
        end
    end

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            for (int s = 0; s < DP; s++) mem[s] <= '0;
        end else if (!flush) begin
            for (int k = 0; k < IN; k++)
                if (k < int'(np)) mem[waddr[k]] <= data_push[DW*k +: DW];
        end
    end

`ifdef GEN_MP_FIFO_EXPOSE_EN
    always_comb begin
        for (int s = 0; s < DP; s++) expose_o[DW*s +: DW] = mem[s];
    end

    // Push and pop slots never coincide: pushes land only in free slots.
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            valid <= '0;
        end else if (flush) begin
            valid <= '0;
        end else begin
            for (int k = 0; k < IN; k++)
                if (k < int'(np)) valid[waddr[k]] <= 1'b1;
            for (int j = 0; j < OUT; j++)
                if (j < int'(nq)) valid[raddr[j]] <= 1'b0;
        end
    end
`endif

endmodule

// File: tb/tb_gen_mp_fifo.sv
// Randomised and directed bench for gen_mp_fifo against a queue model.
module tb_gen_mp_fifo;

    localparam int DW  = 64;
    localparam int AW  = 3;
    localparam int DP  = 1 << AW;
    localparam int IN  = 2;
    localparam int OUT = 2;

    logic                CLK;
    logic                RSTn;
    logic                flush;
    logic [IN-1:0]       push_valid;
    logic [IN-1:0]       push_ready;
    logic [IN*DW-1:0]    data_push;
    logic [OUT-1:0]      pop_valid;
    logic [OUT-1:0]      pop_ready;
    logic [OUT*DW-1:0]   data_pop;
    logic [AW:0]         count;

    int n_vec;
    int n_err;
    logic [DW-1:0] q [$];

    gen_mp_fifo #(.DW(DW), .AW(AW), .IN(IN), .OUT(OUT)) dut (
        .CLK        (CLK),
        .RSTn       (RSTn),
        .flush      (flush),
        .push_valid (push_valid),
        .push_ready (push_ready),
        .data_push  (data_push),
        .pop_valid  (pop_valid),
        .pop_ready  (pop_ready),
        .data_pop   (data_pop),
        .count      (count)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Checks the settled outputs against the model, applies one cycle.
    task automatic cyc(input logic [IN-1:0] pv, input logic [IN*DW-1:0] pd,
                       input logic [OUT-1:0] pr, input logic fl,
                       output int np_o);
        logic [IN-1:0]  exp_pr;
        logic [OUT-1:0] exp_pv;
        int sz, np, nq;
        sz = q.size();
        for (int i = 0; i < IN; i++) exp_pr[i] = (DP - sz) > i;
        for (int j = 0; j < OUT; j++) exp_pv[j] = sz > j;
        chk("count", 64'(count), 64'(sz));
        chk("push_ready", 64'(push_ready), 64'(exp_pr));
        chk("pop_valid", 64'(pop_valid), 64'(exp_pv));
        for (int j = 0; j < OUT; j++)
            if (j < sz) chk("data_pop", data_pop[DW*j +: DW], q[j]);
        np = 0;
        while (np < IN && pv[np] && (DP - sz) > np) np++;
        nq = 0;
        while (nq < OUT && pr[nq] && sz > nq) nq++;
        push_valid = pv;
        data_push  = pd;
        pop_ready  = pr;
        flush      = fl;
        @(posedge CLK);
        #1;
        if (fl) begin
            q.delete();
        end else begin
            for (int j = 0; j < nq; j++) void'(q.pop_front());
            for (int k = 0; k < np; k++) q.push_back(pd[DW*k +: DW]);
        end
        np_o = fl ? 0 : np;
    endtask

    function automatic logic [DW-1:0] rnd64();
        return {$urandom, $urandom};
    endfunction

    initial begin
        int np;
        int seq;
        logic [IN-1:0]  rpv;
        logic [DW-1:0]  rpd [IN];
        logic [OUT-1:0] rpr;
        logic           rfl;
        n_vec      = 0;
        n_err      = 0;
        RSTn       = 1'b0;
        flush      = 1'b0;
        push_valid = '0;
        data_push  = '0;
        pop_ready  = '0;
        repeat (3) @(posedge CLK);
        #1;
        chk("rst_count", 64'(count), 64'd0);
        chk("rst_push_ready", 64'(push_ready), 64'd3);
        chk("rst_pop_valid", 64'(pop_valid), 64'd0);
        @(negedge CLK);
        RSTn = 1'b1;
        @(posedge CLK);
        #1;

        repeat (10) cyc(2'b00, '0, 2'b11, 1'b0, np);

        cyc(2'b11, {64'hB, 64'hA}, 2'b00, 1'b0, np);
        chk("ab_count", 64'(count), 64'd2);
        chk("ab_lane0", data_pop[63:0], 64'hA);
        chk("ab_lane1", data_pop[127:64], 64'hB);
        cyc(2'b00, '0, 2'b01, 1'b0, np);
        chk("pop1_count", 64'(count), 64'd1);
        chk("pop1_lane0", data_pop[63:0], 64'hB);

        cyc(2'b10, {64'hC, 64'h0}, 2'b00, 1'b0, np);
        chk("gap_np", 64'(np), 64'd0);
        chk("gap_count", 64'(count), 64'd1);

        for (int c = 0; c < 3; c++)
            cyc(2'b11, {rnd64(), rnd64()}, 2'b00, 1'b0, np);
        chk("fill7_count", 64'(count), 64'd7);
        chk("fill7_ready", 64'(push_ready), 64'd1);
        cyc(2'b11, {rnd64(), rnd64()}, 2'b00, 1'b0, np);
        chk("full_count", 64'(count), 64'd8);
        chk("full_ready", 64'(push_ready), 64'd0);
        cyc(2'b11, {rnd64(), rnd64()}, 2'b11, 1'b0, np);
        chk("full_pop_np", 64'(np), 64'd0);
        chk("full_pop_count", 64'(count), 64'd6);
        repeat (3) cyc(2'b00, '0, 2'b11, 1'b0, np);
        chk("drain_count", 64'(count), 64'd0);

        seq = 64'h100;
        for (int c = 0; c < 20; c++) begin
            cyc(2'b11, {64'(seq + 1), 64'(seq)}, 2'b11, 1'b0, np);
            seq += 2;
        end
        repeat (2) cyc(2'b00, '0, 2'b11, 1'b0, np);
        chk("wrap_count", 64'(count), 64'd0);

        cyc(2'b11, {rnd64(), rnd64()}, 2'b00, 1'b0, np);
        cyc(2'b11, {rnd64(), rnd64()}, 2'b00, 1'b0, np);
        cyc(2'b01, {rnd64(), rnd64()}, 2'b00, 1'b0, np);
        chk("pre_flush_count", 64'(count), 64'd5);
        cyc(2'b11, {64'hDEAD, 64'hBEEF}, 2'b01, 1'b1, np);
        chk("flush_count", 64'(count), 64'd0);
        chk("flush_pop_valid", 64'(pop_valid), 64'd0);
        cyc(2'b01, {64'h0, 64'h77}, 2'b00, 1'b0, np);
        chk("post_flush_lane0", data_pop[63:0], 64'h77);
        cyc(2'b00, '0, 2'b11, 1'b0, np);

        // Producer holds an unaccepted lane's data until it is taken.
        rpv = '0;
        for (int i = 0; i < IN; i++) rpd[i] = rnd64();
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < IN; i++)
                if (!rpv[i] && ($urandom % 3 != 0)) begin
                    rpv[i] = 1'b1;
                    rpd[i] = rnd64();
                end
            rpr = OUT'($urandom);
            rfl = ($urandom % 50) == 0;
            cyc(rpv, {rpd[1], rpd[0]}, rpr, rfl, np);
            for (int i = 0; i < IN; i++)
                if (rfl || i < np) rpv[i] = 1'b0;
        end
        repeat (5) cyc(2'b00, '0, 2'b11, 1'b0, np);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/gen_mp_fifo.md
Name: gen_mp_fifo

Overview:
- Multi-port, parametrised circular FIFO. Accepts up to IN entries per cycle and releases up to OUT entries per cycle, strictly in order.
- Successor to the single-lane generic FIFO. Used between superscalar pipeline stages, for example decode to issue, and in load/store queues.
- Adds per-lane valid/ready handshakes, an occupancy count, and flush.
- Storage is register-based. No SRAM.

Parameters:
- DW, 64, data width of one entry.
- AW, 3, log2 of depth. DP = 2**AW entries.
- IN, 2, number of push lanes, 1..DP.
- OUT, 2, number of pop lanes, 1..DP.

Ports:
- CLK  input  1  clock, rising edge.
- RSTn  input  1  asynchronous active-low reset.
- flush  input  1  synchronous clear of all entries and pointers.
- push_valid  input  IN  per-lane push request.
- push_ready  output  IN  per-lane space available.
- data_push  input  IN*DW  lane i occupies bits [DW*i +: DW].
- pop_valid  output  OUT  per-lane entry available.
- pop_ready  input  OUT  per-lane consumer accept.
- data_pop  output  OUT*DW  lane j shows the entry at rd_ptr+j.
- count  output  AW+1  current occupancy, 0..DP.

Behaviour:
- Pointers:
  - rd_ptr and wr_ptr are AW+1 bits, wrap modulo 2**(AW+1).
  - Slot index is ptr[AW-1:0].
  - count = wr_ptr - rd_ptr, modulo 2**(AW+1).
  - Empty when count==0. Full when count==DP.
- Reset (RSTn=0, asynchronous):
  - rd_ptr=0, wr_ptr=0, count=0.
  - All storage is 0.
  - push_ready = all ones (given IN <= DP).
  - pop_valid = 0.
- Push side:
  - push_ready[i] = (DP - count) > i. This is combinational from registered state only; it does not depend on pops in the same cycle.
  - Accepted push count np = length of the leading run of lanes with push_valid & push_ready, starting at lane 0.
  - A valid lane after a gap is NOT accepted that cycle; the producer must hold it.
  - Lane k < np writes slot (wr_ptr+k)[AW-1:0]. Then wr_ptr += np.
- Pop side:
  - pop_valid[j] = count > j.
  - data_pop[j] = storage[(rd_ptr+j)[AW-1:0]]. Combinational, zero latency.
  - Accepted pop count nq = length of the leading run of lanes with pop_valid & pop_ready. Then rd_ptr += nq.
- Simultaneous push and pop:
  - Both are computed against the registered count.
  - Next count = count + np - nq.
  - A pop never sees data pushed in the same cycle. There is no bypass.
  - Push into a full FIFO together with a pop is not accepted; space is freed next cycle.
- Flush:
  - Next cycle rd_ptr=wr_ptr=0 and count=0.
  - Pushes and pops in the flush cycle are discarded and do not alter storage semantics.
  - Stale data may remain in storage but is never visible.
- Latency: a push in cycle t is visible on pop_valid[0] in cycle t+1 when the FIFO was empty.
- Wrap-around: slots are indexed modulo DP. Lane addition crosses the DP boundary seamlessly.
- Protocol assertions:
  - np <= DP - count and nq <= count hold by construction.
  - Once push_valid[i]=1, data on that lane is held stable until it is accepted.

Optional Feature:
- Macro: GEN_MP_FIFO_EXPOSE_EN.
- When defined, two extra outputs exist:
  - expose_o (DP*DW): raw storage, slot order.
  - valid (DP): per-slot occupancy bits. Set on push to the slot, cleared on pop from the slot. Flush clears all bits. Reset value is 0.
- When undefined, these ports and the valid-bit flops are absent. All other behaviour is identical.

Decomposition:
- Shared package gen_fifo_pkg holds:
  - clog2 helper function.
  - Typedef for the AW+1 pointer.
  - Constant DP.
- One natural sub-module: gen_lead_cnt, parametrised by lane count N. Input is an N-bit fire vector; output is the count of leading ones, width clog2(N+1). It is instantiated twice, for np and nq.
- Flops use the team's existing reset-flop primitives.

Test Plan (defaults DW=64, AW=3, IN=2, OUT=2):
- Reset, then idle: count=0, pop_valid=00, push_ready=11. No pop fires for 10 cycles.
- Push lanes 0,1 with values 0xA,0xB in one cycle, pop_ready=00:
  - Next cycle count=2, pop_valid=11, data_pop lane0=0xA, lane1=0xB.
  - Then pop_ready=01 gives count=1 and data_pop lane0=0xB.
- Gap rule: push_valid=10 (lane1 only) gives np=0 and count unchanged.
- Fill to count=7:
  - push_ready=01, so a 2-lane push accepts only lane 0 and count=8.
  - At count=8, push_ready=00. A simultaneous pop of 2 leaves count=6 next cycle, with no push accepted.
- Wrap: stream 40 entries at 2/cycle in, 2/cycle out. Output order equals input order, and the pointers wrap at least twice.
- Flush with count=5 while pushing 2 and popping 1: next cycle count=0, pop_valid=00, and the discarded data never appears.
